// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq_ctrl
//  Brief    : Sequencing controller for the lab ALU. Accepts one operation
//             request at a time, drives the shared operand bus and a one-hot
//             init to the selected arithmetic unit, waits for the unit's fixed
//             latency (sum, resta) or its done flag (mult, div), then
//             captures the 2W-bit result and pulses valid. A slow unit that
//             never answers is abandoned after TIMEOUT RUN cycles with
//             result 0 and an err pulse.
//
//  Ports    : clk              system clock, rising edge
//             rst_n            asynchronous reset, active low
//             start            request strobe, sampled only in IDLE
//             opcode[1:0]      00 sum, 01 resta, 10 mult, 11 div
//             a, b [W-1:0]     operands, sampled at the accept edge
//             xi, yi [W-1:0]   registered operand bus to all units
//             init[3:0]        one-hot unit enable, bit index = opcode
//             sal_sum/res/mul/div [2W-1:0]  unit results
//             done_i[3:0]      unit done flags (bits 2 and 3 used)
//             result[2W-1:0]   captured result, held until next capture
//             valid            one-cycle pulse when result updates
//             busy             high from accept edge until capture edge
//             err              one-cycle pulse with valid on timeout
//
//  Revision : 1.0  initial release
// ============================================================================
module alu_seq_ctrl #(
    parameter int W       = 3,
    parameter int TIMEOUT = 15
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [1:0]     opcode,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [W-1:0]   xi,
    output logic [W-1:0]   yi,
    output logic [3:0]     init,
    input  logic [2*W-1:0] sal_sum,
    input  logic [2*W-1:0] sal_res,
    input  logic [2*W-1:0] sal_mul,
    input  logic [2*W-1:0] sal_div,
    input  logic [3:0]     done_i,
    output logic [2*W-1:0] result,
    output logic           valid,
    output logic           busy,
    output logic           err
);

    localparam int                 c_cnt_w   = $clog2(TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_timeout = c_cnt_w'(TIMEOUT);
    localparam logic [c_cnt_w-1:0] c_one     = c_cnt_w'(1);

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_run  = 1'b1;

    logic [0:0]         r_state;
    logic [1:0]         r_op;
    logic [c_cnt_w-1:0] r_cnt;
    logic [W-1:0]       r_xi;
    logic [W-1:0]       r_yi;
    logic [3:0]         r_init;
    logic [2*W-1:0]     r_result;
    logic               r_valid;
    logic               r_busy;
    logic               r_err;

    logic [2*W-1:0]     w_sel;
    logic               w_fast_cap;
    logic               w_done_cap;
    logic               w_timeout;
    logic               w_capture;

    // Result source follows the opcode latched at accept, not the live input.
    always_comb begin
        w_sel = '0;
        case (r_op)
            2'b00:   w_sel = sal_sum;
            2'b01:   w_sel = sal_res;
            2'b10:   w_sel = sal_mul;
            default: w_sel = sal_div;
        endcase
    end

    // Fast units registered their result on the first edge with init high
    // (cnt 0 -> 1), so the value is safe to sample on the next edge.
    assign w_fast_cap = !r_op[1] && (r_cnt == c_one);
    // A done seen in the same cycle as the accept edge is ignored (cnt >= 1).
    assign w_done_cap = r_op[1] && done_i[r_op] && (r_cnt != '0);
    // A real done wins over the timeout when both land on the last cycle.
    assign w_timeout  = r_op[1] && !w_done_cap && (r_cnt == c_timeout);
    assign w_capture  = w_fast_cap || w_done_cap || w_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_st_idle;
            r_op     <= 2'b00;
            r_cnt    <= '0;
            r_xi     <= '0;
            r_yi     <= '0;
            r_init   <= 4'b0000;
            r_result <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    r_init <= 4'b0000;
                    r_busy <= 1'b0;
                    if (start) begin
                        r_xi    <= a;
                        r_yi    <= b;
                        r_op    <= opcode;
                        r_init  <= 4'b0001 << opcode;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= c_st_run;
                    end
                end
                c_st_run: begin
                    // init stays high through this edge so resta does not
                    // clear its output before it is sampled.
                    if (w_capture) begin
                        r_result <= w_timeout ? '0 : w_sel;
                        r_valid  <= 1'b1;
                        r_err    <= w_timeout;
                        r_init   <= 4'b0000;
                        r_busy   <= 1'b0;
                        r_state  <= c_st_idle;
                    end else if (r_cnt != c_timeout) begin
                        r_cnt <= r_cnt + c_one;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign xi     = r_xi;
    assign yi     = r_yi;
    assign init   = r_init;
    assign result = r_result;
    assign valid  = r_valid;
    assign busy   = r_busy;
    assign err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_seq_ctrl
//  Brief    : Self-checking bench for alu_seq_ctrl. Behavioural arithmetic
//             units surround the controller; expected results, latencies and
//             error flags are computed from the operation rules at request
//             time and compared against what the controller delivers.
//
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_seq_ctrl;

    localparam int W       = 3;
    localparam int TIMEOUT = 15;
    localparam int NEVER   = 1000;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [1:0]     opcode;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [W-1:0]   xi;
    logic [W-1:0]   yi;
    logic [3:0]     init;
    logic [2*W-1:0] sal_sum;
    logic [2*W-1:0] sal_res;
    logic [2*W-1:0] sal_mul;
    logic [2*W-1:0] sal_div;
    logic [3:0]     done_i;
    logic [2*W-1:0] result;
    logic           valid;
    logic           busy;
    logic           err;

    int             n_tests = 0;
    int             n_fail  = 0;
    int             cyc     = 0;
    int             ulat    = NEVER;
    int             ucnt    = 0;
    int             last_valid_cyc = 0;
    logic [2*W-1:0] last_res = '0;
    logic [1:0]     noise    = 2'b00;

    alu_seq_ctrl #(.W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .opcode  (opcode),
        .a       (a),
        .b       (b),
        .xi      (xi),
        .yi      (yi),
        .init    (init),
        .sal_sum (sal_sum),
        .sal_res (sal_res),
        .sal_mul (sal_mul),
        .sal_div (sal_div),
        .done_i  (done_i),
        .result  (result),
        .valid   (valid),
        .busy    (busy),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural arithmetic units. sum registers on init; resta registers
    // on init and clears when idle; mult/div raise done ulat edges after
    // their init rises. done_i[1:0] carries noise that must be ignored.
    // ------------------------------------------------------------------
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (init[0]) sal_sum <= {3'b000, xi} + {3'b000, yi};
        sal_res <= init[1] ? {3'b000, 3'(xi - yi)} : 6'd0;
        ucnt    <= (init[2] || init[3]) ? ucnt + 1 : 0;
        noise   <= 2'($urandom);
    end
    initial begin
        sal_sum = '0;
        sal_res = '0;
    end
    assign sal_mul = {3'b000, xi} * {3'b000, yi};
    assign sal_div = (yi == 3'd0) ? 6'h3F : {3'(xi % yi), 3'(xi / yi)};
    assign done_i  = {init[3] && (ucnt >= ulat), init[2] && (ucnt >= ulat), noise};

    // ------------------------------------------------------------------
    // One request. Called at a negedge; returns at the negedge where valid
    // is observed high, so a following call requests in the valid cycle.
    // ------------------------------------------------------------------
    task automatic do_op(input logic [1:0] op, input logic [2:0] ai, input logic [2:0] bi,
                         input int lat, input bit poke);
        logic [5:0] exp_res;
        logic       exp_err;
        int         exp_n;
        int         n;
        case (op)
            2'd0:    exp_res = 6'(ai) + 6'(bi);
            2'd1:    exp_res = {3'b000, 3'(ai - bi)};
            2'd2:    exp_res = 6'(ai) * 6'(bi);
            default: exp_res = (bi == 3'd0) ? 6'h3F : {3'(ai % bi), 3'(ai / bi)};
        endcase
        exp_err = 1'b0;
        if (op < 2'd2) exp_n = 2;
        else if (lat <= TIMEOUT) exp_n = ((lat < 1) ? 1 : lat) + 1;
        else begin
            exp_n   = TIMEOUT + 1;
            exp_err = 1'b1;
            exp_res = '0;
        end

        ulat   = lat;
        start  = 1'b1;
        opcode = op;
        a      = ai;
        b      = bi;
        @(negedge clk);
        start  = 1'b0;
        a      = 3'($urandom);
        b      = 3'($urandom);
        opcode = 2'($urandom);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL accept_busy op=%0d: got %b want 1", op, busy); end
        n_tests++; if (init !== (4'b0001 << op)) begin n_fail++; $display("FAIL accept_init op=%0d: got %b want %b", op, init, 4'b0001 << op); end
        n_tests++; if (xi !== ai || yi !== bi) begin n_fail++; $display("FAIL accept_xy: got %0d,%0d want %0d,%0d", xi, yi, ai, bi); end
        n_tests++; if (valid !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL accept_pulse: got valid=%b err=%b want 0,0", valid, err); end

        n = 0;
        while (valid !== 1'b1 && n < 40) begin
            if (poke && (n == 1 || n == 3)) begin
                start = 1'b1;
                a     = 3'($urandom);
                b     = 3'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
            if (valid !== 1'b1) begin
                n_tests++;
                if (init !== (4'b0001 << op) || xi !== ai || yi !== bi || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL run_stable n=%0d: got init=%b xi=%0d yi=%0d busy=%b want init=%b xi=%0d yi=%0d busy=1",
                             n, init, xi, yi, busy, 4'b0001 << op, ai, bi);
                end
            end
        end
        start = 1'b0;
        last_valid_cyc = cyc;
        n_tests++; if (n != exp_n) begin n_fail++; $display("FAIL latency op=%0d lat=%0d: got %0d edges want %0d", op, lat, n, exp_n); end
        n_tests++; if (result !== exp_res) begin n_fail++; $display("FAIL result op=%0d a=%0d b=%0d: got %0d want %0d", op, ai, bi, result, exp_res); end
        n_tests++; if (err !== exp_err) begin n_fail++; $display("FAIL err op=%0d lat=%0d: got %b want %b", op, lat, err, exp_err); end
        n_tests++; if (busy !== 1'b0 || init !== 4'b0000) begin n_fail++; $display("FAIL capture_idle: got busy=%b init=%b want 0,0000", busy, init); end
        last_res = exp_res;
    endtask

    // One idle cycle: pulses must be gone, result held.
    task automatic idle_cycle();
        @(negedge clk);
        n_tests++; if (valid !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL pulse_width: got valid=%b err=%b want 0,0", valid, err); end
        n_tests++; if (busy !== 1'b0 || init !== 4'b0000) begin n_fail++; $display("FAIL idle_state: got busy=%b init=%b want 0,0000", busy, init); end
        n_tests++; if (result !== last_res) begin n_fail++; $display("FAIL result_hold: got %0d want %0d", result, last_res); end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        start  = 1'b0;
        opcode = 2'b00;
        a      = '0;
        b      = '0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (xi !== 3'd0 || yi !== 3'd0 || init !== 4'd0 || result !== 6'd0 || valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got xi=%0d yi=%0d init=%b result=%0d valid=%b busy=%b err=%b want all 0",
                     xi, yi, init, result, valid, busy, err);
        end
        rst_n = 1'b1;
        last_res = '0;
        idle_cycle();
    endtask

    task automatic test_sum();
        do_op(2'd0, 3'd3, 3'd2, NEVER, 1'b0);
        idle_cycle();
    endtask

    task automatic test_resta_back_to_back();
        int t1;
        do_op(2'd1, 3'd2, 3'd5, NEVER, 1'b0);
        n_tests++; if (result[2:0] !== 3'b101) begin n_fail++; $display("FAIL resta_neg: got %b want 101", result[2:0]); end
        t1 = last_valid_cyc;
        do_op(2'd1, 3'd5, 3'd2, NEVER, 1'b0);
        n_tests++; if (last_valid_cyc - t1 != 3) begin n_fail++; $display("FAIL b2b_spacing: got %0d cycles want 3", last_valid_cyc - t1); end
        idle_cycle();
    endtask

    task automatic test_mult();
        do_op(2'd2, 3'd7, 3'd7, 6, 1'b0);
        idle_cycle();
        do_op(2'd2, 3'd5, 3'd3, 0, 1'b0);
        idle_cycle();
        do_op(2'd3, 3'd7, 3'd2, TIMEOUT, 1'b0);
        idle_cycle();
    endtask

    task automatic test_div_timeout();
        do_op(2'd3, 3'd6, 3'd3, NEVER, 1'b0);
        idle_cycle();
        do_op(2'd0, 3'd7, 3'd7, NEVER, 1'b0);
        idle_cycle();
    endtask

    task automatic test_busy_reject();
        do_op(2'd2, 3'd3, 3'd4, 6, 1'b1);
        idle_cycle();
        idle_cycle();
    endtask

    task automatic test_reset_mid_op();
        ulat   = NEVER;
        start  = 1'b1;
        opcode = 2'd3;
        a      = 3'd5;
        b      = 3'd1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (xi !== 3'd0 || yi !== 3'd0 || init !== 4'd0 || result !== 6'd0 || valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_op: got xi=%0d yi=%0d init=%b result=%0d valid=%b busy=%b err=%b want all 0",
                     xi, yi, init, result, valid, busy, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        last_res = '0;
        for (int i = 0; i < 20; i++) idle_cycle();
        do_op(2'd0, 3'd1, 3'd6, NEVER, 1'b0);
        idle_cycle();
    endtask

    task automatic test_random();
        int lat;
        for (int i = 0; i < 60; i++) begin
            lat = ($urandom_range(0, 4) == 0) ? NEVER : int'($urandom_range(0, 17));
            do_op(2'($urandom), 3'($urandom), 3'($urandom), lat, 1'($urandom));
            if ($urandom_range(0, 1) == 0) idle_cycle();
        end
        idle_cycle();
    endtask

    initial begin
        test_reset();
        test_sum();
        test_resta_back_to_back();
        test_mult();
        test_div_timeout();
        test_busy_reject();
        test_reset_mid_op();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
